// File: rtl/l2_req_arbiter.sv
// L2 request-channel front end: picks one of icache, dcache or the L2 prefetcher,
// latches the winner's request and follows it through addr_ok and data_ok,
// routing each handshake back to its owner.
module l2_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    // icache port
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    input  logic             i_suc,
    output logic             i_addr_ok,
    output logic             i_data_ok,
    // dcache port
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    input  logic [3:0]       d_wstrb,
    input  logic [1:0]       d_size,
    input  logic             d_suc,
    output logic             d_addr_ok,
    output logic             d_data_ok,
    // prefetcher port
    input  logic             p_req,
    input  logic             p_type,
    input  logic [31:0]      p_addr,
    output logic             p_ack,
    // L2 request interface
    output logic             l2_req,
    output logic [1:0]       l2_from,
    output logic [31:0]      l2_addr,
    output logic [31:0]      l2_wdata,
    output logic [3:0]       l2_wstrb,
    output logic [1:0]       l2_size,
    output logic             l2_suc,
    output logic             l2_pref_type,
    input  logic             l2_addr_ok,
    input  logic             l2_data_ok,
    // status
    output logic             busy,
    output logic [CNT_W-1:0] starve_cnt
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    // Owner encoding doubles as the l2_from value.
    localparam logic [1:0] FromPref = 2'd0;
    localparam logic [1:0] FromI    = 2'd1;
    localparam logic [1:0] FromDr   = 2'd2;
    localparam logic [1:0] FromDw   = 2'd3;

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

    state_e           state_q;
    logic             l2_req_q;
    logic [1:0]       owner_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic [1:0]       size_q;
    logic             suc_q;
    logic             pref_type_q;
    logic [CNT_W-1:0] starve_q;

    logic        gnt_i, gnt_d, gnt_p, gnt_any;
    logic [1:0]  sel_from;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;
    logic [1:0]  sel_size;
    logic        sel_suc;
    logic        sel_pref_type;

    logic own_i, own_d, own_p;
    logic in_req, in_wait, accept, pref_abort;

    // Arbitration: a starved icache jumps ahead of dcache, else dcache > icache > pref.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        gnt_p = 1'b0;
        if (i_req && (starve_q == StarveMax)) begin
            gnt_i = 1'b1;
        end else if (d_req) begin
            gnt_d = 1'b1;
        end else if (i_req) begin
            gnt_i = 1'b1;
        end else if (p_req) begin
            gnt_p = 1'b1;
        end
    end

    assign gnt_any = gnt_i | gnt_d | gnt_p;

    // Winner's request fields; icache and prefetch always use word size.
    always_comb begin
        sel_from      = FromPref;
        sel_addr      = p_addr;
        sel_wdata     = 32'd0;
        sel_wstrb     = 4'd0;
        sel_size      = 2'd2;
        sel_suc       = 1'b0;
        sel_pref_type = 1'b0;
        if (gnt_d) begin
            sel_from  = d_wr ? FromDw : FromDr;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
            sel_wstrb = d_wstrb;
            sel_size  = d_size;
            sel_suc   = d_suc;
        end else if (gnt_i) begin
            sel_from = FromI;
            sel_addr = i_addr;
            sel_suc  = i_suc;
        end else if (gnt_p) begin
            sel_pref_type = p_type;
        end
    end

    assign own_i   = (owner_q == FromI);
    assign own_d   = owner_q[1];
    assign own_p   = (owner_q == FromPref);
    assign in_req  = (state_q == StReq);
    assign in_wait = (state_q == StWait);
    assign accept  = in_req && l2_addr_ok;

    // A prefetch is withdrawn, or yields to an L1 request, only before L2 accepts it.
    assign pref_abort = in_req && own_p && !l2_addr_ok && (!p_req || d_req || i_req);

    // Transaction sequencer: latch on grant, hold through REQ, finish on data_ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            l2_req_q    <= 1'b0;
            owner_q     <= FromPref;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            size_q      <= 2'd0;
            suc_q       <= 1'b0;
            pref_type_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_any) begin
                        state_q     <= StReq;
                        l2_req_q    <= 1'b1;
                        owner_q     <= sel_from;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        wstrb_q     <= sel_wstrb;
                        size_q      <= sel_size;
                        suc_q       <= sel_suc;
                        pref_type_q <= sel_pref_type;
                    end
                end
                StReq: begin
                    if (l2_addr_ok) begin
                        l2_req_q <= 1'b0;
                        state_q  <= l2_data_ok ? StIdle : StWait;
                    end else if (pref_abort) begin
                        l2_req_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StWait: begin
                    if (l2_data_ok) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    l2_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts dcache grants taken while icache is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else if (state_q == StIdle) begin
            if (!i_req || gnt_i) begin
                starve_q <= '0;
            end else if (gnt_d && (starve_q != StarveMax)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    // Handshake routing back to the owner; data_ok may ride along with addr_ok.
    always_comb begin
        i_addr_ok = accept && own_i;
        d_addr_ok = accept && own_d;
        p_ack     = accept && own_p;
        i_data_ok = l2_data_ok && own_i && (in_wait || accept);
        d_data_ok = l2_data_ok && own_d && (in_wait || accept);
    end

    assign l2_req       = l2_req_q;
    assign l2_from      = owner_q;
    assign l2_addr      = addr_q;
    assign l2_wdata     = wdata_q;
    assign l2_wstrb     = wstrb_q;
    assign l2_size      = size_q;
    assign l2_suc       = suc_q;
    assign l2_pref_type = pref_type_q;
    assign busy         = (state_q != StIdle);
    assign starve_cnt   = starve_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: arbitration order, starvation bound,
// prefetch abort, write field latching, combined handshakes and async reset.
module tb_l2_req_arbiter;

    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1);

    logic             clk;
    logic             rst;
    logic             i_req;
    logic [31:0]      i_addr;
    logic             i_suc;
    logic             i_addr_ok;
    logic             i_data_ok;
    logic             d_req;
    logic             d_wr;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic [3:0]       d_wstrb;
    logic [1:0]       d_size;
    logic             d_suc;
    logic             d_addr_ok;
    logic             d_data_ok;
    logic             p_req;
    logic             p_type;
    logic [31:0]      p_addr;
    logic             p_ack;
    logic             l2_req;
    logic [1:0]       l2_from;
    logic [31:0]      l2_addr;
    logic [31:0]      l2_wdata;
    logic [3:0]       l2_wstrb;
    logic [1:0]       l2_size;
    logic             l2_suc;
    logic             l2_pref_type;
    logic             l2_addr_ok;
    logic             l2_data_ok;
    logic             busy;
    logic [CNT_W-1:0] starve_cnt;

    int errors = 0;
    int checks = 0;

    l2_req_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_suc       (i_suc),
        .i_addr_ok   (i_addr_ok),
        .i_data_ok   (i_data_ok),
        .d_req       (d_req),
        .d_wr        (d_wr),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wstrb     (d_wstrb),
        .d_size      (d_size),
        .d_suc       (d_suc),
        .d_addr_ok   (d_addr_ok),
        .d_data_ok   (d_data_ok),
        .p_req       (p_req),
        .p_type      (p_type),
        .p_addr      (p_addr),
        .p_ack       (p_ack),
        .l2_req      (l2_req),
        .l2_from     (l2_from),
        .l2_addr     (l2_addr),
        .l2_wdata    (l2_wdata),
        .l2_wstrb    (l2_wstrb),
        .l2_size     (l2_size),
        .l2_suc      (l2_suc),
        .l2_pref_type(l2_pref_type),
        .l2_addr_ok  (l2_addr_ok),
        .l2_data_ok  (l2_data_ok),
        .busy        (busy),
        .starve_cnt  (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs settle here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_suc = 0;
        d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_size = 0; d_suc = 0;
        p_req = 0; p_type = 0; p_addr = 0;
        l2_addr_ok = 0; l2_data_ok = 0;
        #12;
        chk("rst_l2_req", l2_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_starve", starve_cnt, 0);
        chk("rst_addr", l2_addr, 0);
        chk("rst_from", l2_from, 0);
        rst = 1'b0;

        // dcache beats icache; normal addr_ok then data_ok.
        i_req = 1; i_addr = 32'h0000_1100;
        d_req = 1; d_wr = 0; d_addr = 32'h0000_2200; d_size = 2'd2;
        #1;
        chk("idle_no_req", l2_req, 0);
        tick();
        chk("rd_l2_req", l2_req, 1);
        chk("rd_from", l2_from, 2);
        chk("rd_addr", l2_addr, 32'h0000_2200);
        chk("rd_busy", busy, 1);
        chk("rd_starve1", starve_cnt, 1);
        chk("rd_no_aok", d_addr_ok, 0);
        l2_addr_ok = 1; #1;
        chk("rd_d_aok", d_addr_ok, 1);
        chk("rd_i_aok", i_addr_ok, 0);
        tick();
        l2_addr_ok = 0; d_req = 0; #1;
        chk("wait_l2_req", l2_req, 0);
        chk("wait_busy", busy, 1);
        l2_data_ok = 1; #1;
        chk("rd_d_dok", d_data_ok, 1);
        chk("rd_i_dok", i_data_ok, 0);
        tick();
        l2_data_ok = 0; #1;
        chk("bubble_busy", busy, 0);
        tick();
        chk("i_from", l2_from, 1);
        chk("i_addr", l2_addr, 32'h0000_1100);
        chk("i_size", l2_size, 2);
        chk("i_starve_clr", starve_cnt, 0);
        // addr_ok and data_ok together.
        l2_addr_ok = 1; l2_data_ok = 1; #1;
        chk("i_both_aok", i_addr_ok, 1);
        chk("i_both_dok", i_data_ok, 1);
        tick();
        l2_addr_ok = 0; l2_data_ok = 0; i_req = 0; #1;
        chk("i_both_idle", busy, 0);

        // Starvation: eight dcache grants, then icache is forced through.
        i_req = 1; d_req = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("starve_from_d", l2_from, 2);
            chk("starve_cnt", starve_cnt, k + 1);
            l2_addr_ok = 1; l2_data_ok = 1;
            tick();
            l2_addr_ok = 0; l2_data_ok = 0;
        end
        tick();
        chk("starve_force_i", l2_from, 1);
        chk("starve_clr", starve_cnt, 0);
        l2_addr_ok = 1; l2_data_ok = 1;
        tick();
        l2_addr_ok = 0; l2_data_ok = 0; i_req = 0; d_req = 0;

        // Prefetch alone, then aborted by an L1 request before addr_ok.
        p_req = 1; p_type = 1; p_addr = 32'h0000_3300;
        tick();
        chk("p_from", l2_from, 0);
        chk("p_type", l2_pref_type, 1);
        chk("p_addr", l2_addr, 32'h0000_3300);
        chk("p_size", l2_size, 2);
        i_req = 1; i_addr = 32'h0000_4400;
        d_req = 1; d_wr = 1; d_addr = 32'h1000_0040; d_wdata = 32'hCAFE_F00D;
        d_wstrb = 4'b0011; d_size = 2'd1; d_suc = 1;
        #1;
        chk("p_no_ack", p_ack, 0);
        tick();
        chk("abort_l2_req", l2_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_ack", p_ack, 0);
        tick();
        chk("w_from", l2_from, 3);
        chk("w_addr", l2_addr, 32'h1000_0040);
        chk("w_wdata", l2_wdata, 32'hCAFE_F00D);
        chk("w_wstrb", l2_wstrb, 4'b0011);
        chk("w_size", l2_size, 1);
        chk("w_suc", l2_suc, 1);
        tick();
        chk("w_hold_req", l2_req, 1);
        chk("w_hold_strb", l2_wstrb, 4'b0011);
        chk("w_starve", starve_cnt, 1);
        l2_addr_ok = 1; #1;
        chk("w_d_aok", d_addr_ok, 1);
        chk("w_p_ack", p_ack, 0);
        tick();
        l2_addr_ok = 0; d_req = 0; #1;
        chk("w_wait_busy", busy, 1);
        // Async reset in WAIT.
        rst = 1; #1;
        chk("arst_busy", busy, 0);
        chk("arst_l2_req", l2_req, 0);
        chk("arst_starve", starve_cnt, 0);
        chk("arst_addr", l2_addr, 0);
        rst = 0;

        // Resume: icache over pref; stray data_ok before addr_ok is dropped.
        tick();
        chk("res_from", l2_from, 1);
        chk("res_addr", l2_addr, 32'h0000_4400);
        l2_data_ok = 1; #1;
        chk("stray_dok", i_data_ok, 0);
        l2_data_ok = 0; l2_addr_ok = 1; #1;
        chk("res_i_aok", i_addr_ok, 1);
        tick();
        l2_addr_ok = 0; i_req = 0; l2_data_ok = 1; #1;
        chk("res_i_dok", i_data_ok, 1);
        chk("res_d_dok", d_data_ok, 0);
        tick();
        l2_data_ok = 0;

        // Prefetch past addr_ok is never aborted even if withdrawn.
        tick();
        chk("p2_from", l2_from, 0);
        l2_addr_ok = 1; #1;
        chk("p2_ack", p_ack, 1);
        tick();
        l2_addr_ok = 0; p_req = 0; d_req = 1; d_wr = 0; #1;
        chk("p2_wait_busy", busy, 1);
        l2_data_ok = 1; #1;
        chk("p2_no_d_dok", d_data_ok, 0);
        tick();
        l2_data_ok = 0; #1;
        chk("p2_idle", busy, 0);
        tick();
        chk("p2_next_d", l2_from, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
